// File: rtl/dof_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dof_ex_stage_pkg
// Purpose  : Control-word layout, instruction field slices and shared constants
//            for the DOF/EX boundary.
// Revision : 1.0 - initial release
// ============================================================================
package dof_ex_stage_pkg;

   // Control word: {RW, MD[1:0], BS[1:0], PS, MW, FS[4:0], MB, MA, CS}
   localparam int RW_BIT = 14;
   localparam int MD_HI  = 13;
   localparam int MD_LO  = 12;
   localparam int BS_HI  = 11;
   localparam int BS_LO  = 10;
   localparam int PS_BIT = 9;
   localparam int MW_BIT = 8;
   localparam int FS_HI  = 7;
   localparam int FS_LO  = 3;
   localparam int MB_BIT = 2;
   localparam int MA_BIT = 1;
   localparam int CS_BIT = 0;

   localparam logic [1:0]  MD_LOAD  = 2'b01;
   localparam logic [14:0] CTRL_NOP = 15'b0;

   // Instruction fields
   localparam int IR_DR_HI  = 24;
   localparam int IR_DR_LO  = 20;
   localparam int IR_SA_HI  = 19;
   localparam int IR_SA_LO  = 15;
   localparam int IR_SB_HI  = 14;
   localparam int IR_SB_LO  = 10;
   localparam int IR_IMM_HI = 14;
   localparam int IR_IMM_LO = 0;
   localparam int IMM_W     = IR_IMM_HI - IR_IMM_LO + 1;

endpackage : dof_ex_stage_pkg
`default_nettype wire

// File: rtl/dof_ex_stage_operand_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module   : operand_bypass_mux
// Purpose  : Selects one source operand from R0, EX forward, WB forward or the
//            register-file read data.
// Revision : 1.0 - initial release
// ============================================================================
module operand_bypass_mux #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input  logic [RA_W-1:0]   addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_fwd_en,
   input  logic [RA_W-1:0]   ex_dr,
   input  logic [DATA_W-1:0] ex_res,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_dr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] data_out
);

   // EX result is younger than WB, so it takes priority
   always_comb begin
      data_out = rf_data;
      if (addr == '0) begin
         data_out = '0;
      end else if (ex_fwd_en && (ex_dr == addr)) begin
         data_out = ex_res;
      end else if (wb_we && (wb_dr == addr)) begin
         data_out = wb_data;
      end
   end

endmodule : operand_bypass_mux
`default_nettype wire

// File: rtl/dof_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : dof_ex_stage
// Purpose  : DOF/EX pipeline register with operand muxing, bypass, load-use
//            stall and branch flush.
// Revision : 1.0 - initial release
// ============================================================================
module dof_ex_stage
   import dof_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int CTRL_W = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       ir_in,
   input  logic [31:0]       pc_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] rf_a_in,
   input  logic [DATA_W-1:0] rf_b_in,
   input  logic [DATA_W-1:0] ex_res_in,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_dr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [RA_W-1:0]   ex_dr,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [31:0]       ex_pc
);

   logic              r_ex_valid;
   logic [CTRL_W-1:0] r_ex_ctrl;
   logic [RA_W-1:0]   r_ex_dr;
   logic [DATA_W-1:0] r_ex_a;
   logic [DATA_W-1:0] r_ex_b;
   logic [31:0]       r_ex_pc;

   logic [RA_W-1:0]   w_dr;
   logic [RA_W-1:0]   w_sa;
   logic [RA_W-1:0]   w_sb;
   logic [IMM_W-1:0]  w_imm;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_byp_a;
   logic [DATA_W-1:0] w_byp_b;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic              w_ex_fwd_en;
   logic              w_ex_load;
   logic              w_uses_ex_dr;
   logic              w_hazard;
   logic              w_bubble;
   logic              w_unused;

   assign w_dr  = ir_in[IR_DR_HI:IR_DR_LO];
   assign w_sa  = ir_in[IR_SA_HI:IR_SA_LO];
   assign w_sb  = ir_in[IR_SB_HI:IR_SB_LO];
   assign w_imm = ir_in[IR_IMM_HI:IR_IMM_LO];
   assign w_unused = ^ir_in[31:IR_DR_HI+1];

   assign w_imm_ext = {{(DATA_W-IMM_W){ctrl_in[CS_BIT] & w_imm[IMM_W-1]}}, w_imm};

   // A load's EX result is an address, not data, so it must never be forwarded
   assign w_ex_fwd_en = r_ex_valid & r_ex_ctrl[RW_BIT] &
                        (r_ex_ctrl[MD_HI:MD_LO] != MD_LOAD);
   assign w_ex_load   = r_ex_valid & r_ex_ctrl[RW_BIT] &
                        (r_ex_ctrl[MD_HI:MD_LO] == MD_LOAD) & (r_ex_dr != '0);

   assign w_uses_ex_dr = (~ctrl_in[MA_BIT] & (w_sa == r_ex_dr)) |
                         (~ctrl_in[MB_BIT] & (w_sb == r_ex_dr));
   assign w_hazard  = w_ex_load & (ctrl_in != CTRL_NOP) & w_uses_ex_dr;
   assign stall_out = w_hazard & ~flush;
   assign w_bubble  = flush | stall_out;

   operand_bypass_mux #(
      .DATA_W (DATA_W),
      .RA_W   (RA_W)
   ) u_byp_a (
      .addr      (w_sa),
      .rf_data   (rf_a_in),
      .ex_fwd_en (w_ex_fwd_en),
      .ex_dr     (r_ex_dr),
      .ex_res    (ex_res_in),
      .wb_we     (wb_we),
      .wb_dr     (wb_dr),
      .wb_data   (wb_data),
      .data_out  (w_byp_a)
   );

   operand_bypass_mux #(
      .DATA_W (DATA_W),
      .RA_W   (RA_W)
   ) u_byp_b (
      .addr      (w_sb),
      .rf_data   (rf_b_in),
      .ex_fwd_en (w_ex_fwd_en),
      .ex_dr     (r_ex_dr),
      .ex_res    (ex_res_in),
      .wb_we     (wb_we),
      .wb_dr     (wb_dr),
      .wb_data   (wb_data),
      .data_out  (w_byp_b)
   );

   assign w_op_a = ctrl_in[MA_BIT] ? pc_in     : w_byp_a;
   assign w_op_b = ctrl_in[MB_BIT] ? w_imm_ext : w_byp_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_dr    <= '0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_pc    <= '0;
      end else if (w_bubble) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_dr    <= '0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_pc    <= '0;
      end else begin
         r_ex_valid <= (ctrl_in != CTRL_NOP);
         r_ex_ctrl  <= ctrl_in;
         r_ex_dr    <= w_dr;
         r_ex_a     <= w_op_a;
         r_ex_b     <= w_op_b;
         r_ex_pc    <= pc_in;
      end
   end

   assign ex_valid = r_ex_valid;
   assign ex_ctrl  = r_ex_ctrl;
   assign ex_dr    = r_ex_dr;
   assign ex_a     = r_ex_a;
   assign ex_b     = r_ex_b;
   assign ex_pc    = r_ex_pc;

endmodule : dof_ex_stage
`default_nettype wire
